div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-low reset.
REQ-002 The block SHALL have the following remaining ports.
- signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  in  32  dividend; sampled with start.
- opdata2_i  in  32  divisor; sampled with start.
- start_i  in  1  request from the EX-stage ALU; held high until the result is consumed.
- annul_i  in  1  abort request, e.g. on exception flush.
- result_o  out  64  {remainder[63:32], quotient[31:0]}; this is the hi/lo write data.
- ready_o  out  1  result valid; the ALU drives its ok signal from this.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, DIVZERO, ON and END.
REQ-004 In IDLE, on an edge with start_i=1 and annul_i=0, the block SHALL latch the operands and signed_div_i, then:
- go to DIVZERO if the divisor = 0;
- otherwise go to ON with cnt=0.
This edge is E0.
REQ-005 In IDLE, annul_i=1 SHALL block acceptance of start_i.
REQ-006 In signed mode, the block SHALL divide the absolute values of the latched operands, using 32-bit two's-complement negation.
REQ-007 In ON, each edge SHALL perform one restoring shift-subtract step on a 65-bit working register and increment the 6-bit cnt.
REQ-008 Edges E1..E32 SHALL perform the 32 steps; at E33 (cnt=32) the FSM SHALL go to END with the final result registered.
REQ-009 Signed sign correction SHALL be:
- quotient negated if the dividend and divisor signs differ;
- remainder takes the sign of the dividend.
REQ-010 DIVZERO SHALL go to END at the next edge (E1) with result_o = 0.
REQ-011 ready_o SHALL be 1 only while in END; result_o SHALL be 0 in every other state.
REQ-012 Outputs SHALL be registered, with no combinational path from any input to result_o or ready_o.
REQ-013 Latency SHALL be:
- ready_o high in the cycle after E33 for a nonzero divisor;
- ready_o high in the cycle after E1 for a zero divisor.
REQ-014 In END, the block SHALL stay in END while start_i=1 and go to IDLE at the first edge with start_i=0, after which ready_o=0.
REQ-015 annul_i=1 in ON, DIVZERO or END SHALL force IDLE at the next edge, and ready_o SHALL not rise for the annulled operation.
REQ-016 After an annul, the block SHALL accept a new start_i no earlier than the edge following the return to IDLE.
REQ-017 Operand or start_i changes in ON and DIVZERO SHALL be ignored; only annul_i aborts.
REQ-018 Overflow 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000, remainder 0; no trap is raised.
REQ-019 When annul_i and the final step coincide (annul at E33), annul SHALL win: go to IDLE, ready_o stays 0.

Reset
REQ-020 rst_i=0 SHALL immediately force, regardless of clock:
- state to IDLE;
- cnt to 0;
- working and latched registers to 0;
- result_o to 0;
- ready_o to 0.
REQ-021 Reset asserted mid-operation SHALL discard the operation, with no ready_o pulse after release.
REQ-022 The first start_i SHALL be accepted at the first rising edge after rst_i deasserts.

Verification
REQ-023 The bench SHALL cover these directed scenarios.
- Unsigned 100/7, start held high -> ready_o=1 after E33, result_o = 0x00000002_0000000E; start_i low -> ready_o=0 next cycle.
- Signed 0xFFFFFFF9 (-7) / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD (rem -1, quot -3) after E33.
- Unsigned 5/0 -> ready_o=1 after E1, result_o = 0.
- Signed 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000; also unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- annul_i pulsed at E10 of a 100/7 divide -> IDLE after E11, ready_o never rises; an immediate new start 9/3 -> result 0x00000000_00000003.
- rst_i low asynchronously at E20 -> result_o=0 and ready_o=0 without a clock edge; no later ready_o until a new start.

Source files
------------

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Request/response bundle between the EX-stage ALU and the
//                multi-cycle divider (operands, control, hi/lo result).
//  Revision    : 1.0  initial release
// ============================================================================
interface div_unit_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  // Requester side (ALU / testbench)
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  // Divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : 32-bit signed/unsigned restoring divider, one quotient bit
//                per clock. result_o = {remainder, quotient}, ready_o while
//                the result is held for the requester.
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit (
  input  wire logic  clk_i,
  input  wire logic  rst_i,
  div_unit_if.slave  bus
);

  localparam logic [5:0] c_LAST_CNT = 6'd32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic        r_signed;
  logic [64:0] r_work;
  logic [63:0] r_result;
  logic        r_ready;

  logic        w_accept;
  logic [31:0] w_abs_dvnd;
  logic [31:0] w_abs_dvsr;
  logic [64:0] w_work_src;
  logic [33:0] w_diff;
  logic [64:0] w_step;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_neg_q;
  logic        w_neg_r;
  logic [63:0] w_final;

  assign w_accept   = (r_state == S_IDLE) && bus.start_i && !bus.annul_i;

  // Magnitudes of the latched operands; 0x80000000 negates to itself.
  assign w_abs_dvnd = (r_signed && r_op1[31]) ? (~r_op1 + 32'd1) : r_op1;
  assign w_abs_dvsr = (r_signed && r_op2[31]) ? (~r_op2 + 32'd1) : r_op2;

  // The first step seeds the working register with the dividend magnitude,
  // so the operand latch edge does no arithmetic.
  assign w_work_src = (r_cnt == 6'd0) ? {33'd0, w_abs_dvnd} : r_work;

  // Shift the partial remainder left by one and trial-subtract the divisor.
  // The shifted remainder is below 2^33, so bit 33 of the difference is the
  // borrow.
  assign w_diff = w_work_src[64:31] - {2'b00, w_abs_dvsr};
  assign w_step = w_diff[33] ? {w_work_src[63:0], 1'b0}
                             : {w_diff[32:0], w_work_src[30:0], 1'b1};

  // Sign correction: quotient negative when signs differ, remainder follows
  // the dividend.
  assign w_quot  = r_work[31:0];
  assign w_rem   = r_work[63:32];
  assign w_neg_q = r_signed && (r_op1[31] ^ r_op2[31]);
  assign w_neg_r = r_signed && r_op1[31];
  assign w_final = {(w_neg_r ? (~w_rem + 32'd1) : w_rem),
                    (w_neg_q ? (~w_quot + 32'd1) : w_quot)};

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; annul aborts every busy state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          w_state_nxt = (bus.opdata2_i == 32'd0) ? S_DIVZERO : S_ON;
        end
      end
      S_DIVZERO: begin
        w_state_nxt = bus.annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        if (bus.annul_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_LAST_CNT) begin
          w_state_nxt = S_END;
        end
      end
      S_END: begin
        if (bus.annul_i || !bus.start_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt    <= 6'd0;
      r_op1    <= 32'd0;
      r_op2    <= 32'd0;
      r_signed <= 1'b0;
      r_work   <= 65'd0;
      r_result <= 64'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op1    <= bus.opdata1_i;
        r_op2    <= bus.opdata2_i;
        r_signed <= bus.signed_div_i;
        r_work   <= 65'd0;
        r_cnt    <= 6'd0;
      end else if ((r_state == S_ON) && !bus.annul_i && (r_cnt != c_LAST_CNT)) begin
        r_work <= w_step;
        r_cnt  <= r_cnt + 6'd1;
      end

      // Ready and result track entry into / presence in END.
      r_ready <= (w_state_nxt == S_END);
      if (w_state_nxt != S_END) begin
        r_result <= 64'd0;
      end else if (r_state == S_ON) begin
        r_result <= w_final;
      end
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Directed self-checking bench for div_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask

  // Count edges after acceptance until ready_o, scrambling operands meanwhile.
  task automatic start_and_wait(input logic sgn, input logic [31:0] a,
                                input logic [31:0] b, output int n);
    drive(sgn, a, b);
    tick;
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~sgn;
    n = 0;
    while (!bus.ready_o && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic watch(input int k, output int hits);
    hits = 0;
    repeat (k) begin
      tick;
      if (bus.ready_o) hits++;
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int n;
    start_and_wait(sgn, a, b, n);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_res"}, bus.result_o, exp);
    tick;
    check({tag, "_hold_rdy"}, 64'(bus.ready_o), 64'd1);
    check({tag, "_hold_res"}, bus.result_o, exp);
    bus.start_i = 1'b0;
    tick;
    check({tag, "_rel_rdy"}, 64'(bus.ready_o), 64'd0);
    check({tag, "_rel_res"}, bus.result_o, 64'd0);
  endtask

  initial begin
    int n;
    int hits;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    rst_n            = 1'b0;

    repeat (3) tick;
    check("rst_rdy", 64'(bus.ready_o), 64'd0);
    check("rst_res", bus.result_o, 64'd0);
    rst_n = 1'b1;

    // Basic vectors
    run_div("u100_7",    1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33);
    run_div("s_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("u5_0",      1'b0, 32'd5,         32'd0,         64'h0,                  1);
    run_div("s_m1_0",    1'b1, 32'hFFFFFFFF,  32'd0,         64'h0,                  1);
    run_div("s_ovf",     1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33);
    run_div("u_max_1",   1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 33);
    run_div("s_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33);
    run_div("u_fff9_2",  1'b0, 32'hFFFFFFF9,  32'd2,         64'h00000001_7FFFFFFC, 33);
    run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 33);

    // Annul during ON, then an immediate new request
    drive(1'b0, 32'd100, 32'd7);
    tick;
    hits = 0;
    repeat (10) begin
      tick;
      if (bus.ready_o) hits++;
    end
    bus.annul_i = 1'b1;
    tick;
    if (bus.ready_o) hits++;
    check("annul_on_rdy", 64'(hits), 64'd0);
    bus.annul_i = 1'b0;
    run_div("annul_next", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Annul held in IDLE blocks acceptance
    drive(1'b0, 32'd9, 32'd3);
    bus.annul_i = 1'b1;
    tick;
    tick;
    check("annul_idle_rdy", 64'(bus.ready_o), 64'd0);
    bus.annul_i = 1'b0;
    run_div("idle_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Annul coinciding with the final edge
    drive(1'b0, 32'd100, 32'd7);
    tick;
    repeat (32) tick;
    bus.annul_i = 1'b1;
    tick;
    check("annul_e33_rdy", 64'(bus.ready_o), 64'd0);
    check("annul_e33_res", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    watch(5, hits);
    check("annul_e33_after", 64'(hits), 64'd0);

    // Annul in DIVZERO
    drive(1'b0, 32'd5, 32'd0);
    tick;
    bus.annul_i = 1'b1;
    tick;
    check("annul_dz_rdy", 64'(bus.ready_o), 64'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    watch(3, hits);
    check("annul_dz_after", 64'(hits), 64'd0);

    // Annul in END while start is still held
    start_and_wait(1'b0, 32'd100, 32'd7, n);
    check("annul_end_lat", 64'(n), 64'd33);
    bus.annul_i = 1'b1;
    tick;
    check("annul_end_rdy", 64'(bus.ready_o), 64'd0);
    check("annul_end_res", bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick;

    // Asynchronous reset mid-operation discards it
    drive(1'b0, 32'd100, 32'd7);
    tick;
    repeat (20) tick;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rdy", 64'(bus.ready_o), 64'd0);
    check("rst_mid_res", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    tick;
    rst_n = 1'b1;
    watch(40, hits);
    check("rst_mid_after", 64'(hits), 64'd0);

    // Asynchronous reset in END clears outputs without a clock edge
    start_and_wait(1'b0, 32'd100, 32'd7, n);
    check("rst_end_res0", bus.result_o, 64'h00000002_0000000E);
    #2 rst_n = 1'b0;
    #1;
    check("rst_end_rdy", 64'(bus.ready_o), 64'd0);
    check("rst_end_res", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    tick;
    rst_n = 1'b1;
    run_div("post_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
